// File: rtl/instr_compress_packer_pkg.sv
// Shared constants for the RVC instruction packer: RV32I opcodes/funct3,
// RVC quadrant/funct3 encodings, the default pad parcel and the packer state type.
package instr_compress_packer_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_SRA     = 7'b0100000;

    localparam logic [1:0] RVC_Q0 = 2'b00;
    localparam logic [1:0] RVC_Q1 = 2'b01;
    localparam logic [1:0] RVC_Q2 = 2'b10;

    localparam logic [2:0] C_F3_LW    = 3'b010;
    localparam logic [2:0] C_F3_SW    = 3'b110;
    localparam logic [2:0] C_F3_ADDI  = 3'b000;
    localparam logic [2:0] C_F3_SLLI  = 3'b000;
    localparam logic [2:0] C_F3_JAL   = 3'b001;
    localparam logic [2:0] C_F3_J     = 3'b101;
    localparam logic [2:0] C_F3_MISC  = 3'b100;
    localparam logic [2:0] C_F3_BEQZ  = 3'b110;
    localparam logic [2:0] C_F3_BNEZ  = 3'b111;

    localparam logic [15:0] NOP_PAD_DEFAULT = 16'h0001;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_t;

    // Registers x8..x15 are the only ones reachable by the 3-bit RVC fields.
    function automatic logic is_creg(input logic [4:0] r);
        return r[4:3] == 2'b01;
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/instr_compress_packer_rvc_compress.sv
// Combinational RV32I -> RVC converter; flags whether a 16-bit parcel was produced.
module rvc_compress
    import instr_compress_packer_pkg::*;
(
    input  logic [31:0] instr,
    output logic [15:0] parcel,
    output logic        is_compressed
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] i_imm;
    logic [11:0] s_imm;
    logic [12:1] b_imm;
    logic [20:1] j_imm;
    logic        i_small;

    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign f3      = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign f7      = instr[31:25];
    assign i_imm   = instr[31:20];
    assign s_imm   = {instr[31:25], instr[11:7]};
    assign b_imm   = {instr[31], instr[7], instr[30:25], instr[11:8]};
    assign j_imm   = {instr[31], instr[19:12], instr[20], instr[30:21]};
    assign i_small = (i_imm[11:5] == {7{i_imm[5]}});

    // First matching rule wins, so c.add shadows c.mv on any overlap.
    always_comb begin
        parcel        = '0;
        is_compressed = 1'b0;
        if (opcode == OP_LOAD && f3 == F3_WORD && is_creg(rd) && is_creg(rs1)
            && i_imm[11:7] == 5'd0 && i_imm[1:0] == 2'd0) begin
            parcel        = {C_F3_LW, i_imm[5:3], rs1[2:0], i_imm[2], i_imm[6], rd[2:0], RVC_Q0};
            is_compressed = 1'b1;
        end else if (opcode == OP_STORE && f3 == F3_WORD && is_creg(rs1) && is_creg(rs2)
            && s_imm[11:7] == 5'd0 && s_imm[1:0] == 2'd0) begin
            parcel        = {C_F3_SW, s_imm[5:3], rs1[2:0], s_imm[2], s_imm[6], rs2[2:0], RVC_Q0};
            is_compressed = 1'b1;
        end else if (opcode == OP_IMM && f3 == F3_ADD_SUB
            && ((rd == 5'd0 && rs1 == 5'd0 && i_imm == 12'd0)
             || (rd != 5'd0 && rd == rs1 && i_imm != 12'd0 && i_small))) begin
            parcel        = {C_F3_ADDI, i_imm[5], rd, i_imm[4:0], RVC_Q1};
            is_compressed = 1'b1;
        end else if (opcode == OP_IMM && f3 == F3_SLL && f7 == F7_ZERO
            && rd != 5'd0 && rd == rs1 && rs2 != 5'd0) begin
            parcel        = {C_F3_SLLI, 1'b0, rd, rs2, RVC_Q2};
            is_compressed = 1'b1;
        end else if (opcode == OP_IMM && f3 == F3_SRL_SRA && (f7 == F7_ZERO || f7 == F7_SRA)
            && is_creg(rd) && rd == rs1 && rs2 != 5'd0) begin
            parcel        = {C_F3_MISC, 1'b0, 1'b0, f7[5], rd[2:0], rs2, RVC_Q1};
            is_compressed = 1'b1;
        end else if (opcode == OP_IMM && f3 == F3_AND && is_creg(rd) && rd == rs1 && i_small) begin
            parcel        = {C_F3_MISC, i_imm[5], 2'b10, rd[2:0], i_imm[4:0], RVC_Q1};
            is_compressed = 1'b1;
        end else if (opcode == OP_JAL && (rd == 5'd0 || rd == 5'd1)
            && j_imm[20:11] == {10{j_imm[11]}}) begin
            parcel        = {(rd[0] ? C_F3_JAL : C_F3_J), j_imm[11], j_imm[4], j_imm[9:8],
                             j_imm[10], j_imm[6], j_imm[7], j_imm[3:1], j_imm[5], RVC_Q1};
            is_compressed = 1'b1;
        end else if (opcode == OP_BRANCH && (f3 == F3_BEQ || f3 == F3_BNE) && is_creg(rs1)
            && rs2 == 5'd0 && b_imm[12:8] == {5{b_imm[8]}}) begin
            parcel        = {(f3 == F3_BNE ? C_F3_BNEZ : C_F3_BEQZ), b_imm[8], b_imm[4:3],
                             rs1[2:0], b_imm[7:6], b_imm[2:1], b_imm[5], RVC_Q1};
            is_compressed = 1'b1;
        end else if (opcode == OP_JALR && f3 == 3'b000 && (rd == 5'd0 || rd == 5'd1)
            && rs1 != 5'd0 && i_imm == 12'd0) begin
            parcel        = {C_F3_MISC, rd[0], rs1, 5'd0, RVC_Q2};
            is_compressed = 1'b1;
        end else if (opcode == OP_OP && f3 == F3_ADD_SUB && f7 == F7_ZERO
            && rd != 5'd0 && rs2 != 5'd0 && rd == rs1) begin
            parcel        = {C_F3_MISC, 1'b1, rd, rs2, RVC_Q2};
            is_compressed = 1'b1;
        end else if (opcode == OP_OP && f3 == F3_ADD_SUB && f7 == F7_ZERO
            && rd != 5'd0 && rs2 != 5'd0 && rs1 == 5'd0) begin
            parcel        = {C_F3_MISC, 1'b0, rd, rs2, RVC_Q2};
            is_compressed = 1'b1;
        end
    end

endmodule

// File: rtl/instr_compress_packer.sv
// Packs a stream of RV32I instructions into 32-bit words, compressing to RVC
// where possible and carrying a leftover halfword across instructions.
module instr_compress_packer
    import instr_compress_packer_pkg::*;
#(
    parameter logic [15:0] NOP_PAD = NOP_PAD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        pending
);

    state_t      state;
    state_t      next_state;
    logic [15:0] ph;
    logic [15:0] next_ph;
    logic [31:0] canon;
    logic [31:0] next_canon;
    logic [15:0] parcel;
    logic        is_compressed;
    logic        accept;
    logic        flush_fire;
    logic        load_out;

    assign canon      = bswap32(in_instr);
    assign in_ready   = (!out_valid || out_ready) && !flush;
    assign accept     = in_valid && in_ready;
    assign flush_fire = flush && (state == ST_HALF) && (!out_valid || out_ready);
    assign pending    = (state == ST_HALF);

    rvc_compress u_rvc_compress (
        .instr         (canon),
        .parcel        (parcel),
        .is_compressed (is_compressed)
    );

    // The lower-address halfword always lands in canonical bits [15:0].
    always_comb begin
        next_state = state;
        next_ph    = ph;
        next_canon = '0;
        load_out   = 1'b0;
        if (accept) begin
            if (state == ST_EMPTY) begin
                if (is_compressed) begin
                    next_ph    = parcel;
                    next_state = ST_HALF;
                end else begin
                    next_canon = canon;
                    load_out   = 1'b1;
                end
            end else begin
                load_out = 1'b1;
                if (is_compressed) begin
                    next_canon = {parcel, ph};
                    next_state = ST_EMPTY;
                end else begin
                    next_canon = {canon[15:0], ph};
                    next_ph    = canon[31:16];
                end
            end
        end else if (flush_fire) begin
            next_canon = {NOP_PAD, ph};
            next_state = ST_EMPTY;
            load_out   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            ph        <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
        end else begin
            state <= next_state;
            ph    <= next_ph;
            if (load_out) begin
                out_word  <= bswap32(next_canon);
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_compress_packer.sv
// Scoreboard bench for instr_compress_packer: a small packing model pushes
// expected words, a negedge monitor pops and compares on every output transfer.
module tb_instr_compress_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        pending;

    int          checkCount = 0;
    int          passCount  = 0;
    int          xferCount  = 0;
    logic [31:0] sb[$];
    logic        mHalf = 1'b0;
    logic [15:0] mPh   = '0;
    bit          randBp = 1'b0;

    typedef struct {
        logic [31:0] canon;
        logic        comp;
        logic [15:0] parcel;
    } vec_t;

    vec_t vecs[$];

    instr_compress_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        else
            passCount++;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            xferCount++;
            checkOutput("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0)
                checkOutput("out_word", out_word, sb.pop_front());
        end
    end

    task automatic pushCanon(input logic [31:0] c);
        sb.push_back(swap(c));
    endtask

    task automatic applyStimulus(input logic [31:0] canon, input logic comp, input logic [15:0] parcel);
        int  waited = 0;
        bit  produced = 1'b0;
        in_instr = swap(canon);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            if (randBp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (randBp) out_ready = 1'($urandom_range(0, 1));
        if (!mHalf) begin
            if (comp) begin
                mPh   = parcel;
                mHalf = 1'b1;
            end else begin
                pushCanon(canon);
                produced = 1'b1;
            end
        end else begin
            produced = 1'b1;
            if (comp) begin
                pushCanon({parcel, mPh});
                mHalf = 1'b0;
            end else begin
                pushCanon({canon[15:0], mPh});
                mPh = canon[31:16];
            end
        end
        checkOutput("pending", 32'(pending), 32'(mHalf));
        if (produced)
            checkOutput("out_valid_latency", 32'(out_valid), 32'd1);
    endtask

    task automatic doFlush();
        bit produced = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_flush", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (mHalf) begin
            pushCanon({16'h0001, mPh});
            mHalf    = 1'b0;
            produced = 1'b1;
        end
        checkOutput("pending_flush", 32'(pending), 32'd0);
        if (produced)
            checkOutput("out_valid_flush", 32'(out_valid), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n0;
        int waited;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_pending", 32'(pending), 32'd0);
        checkOutput("rst_out_word", out_word, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        $display("[TB] two c.addi parcels pack into one word");
        applyStimulus(32'h00140413, 1'b1, 16'h0405);
        applyStimulus(32'h00140413, 1'b1, 16'h0405);
        $display("[TB] uncompressible lui from empty");
        applyStimulus(32'h123452B7, 1'b0, 16'h0000);
        $display("[TB] parcel then lui straddles, then flush pads");
        applyStimulus(32'h00140413, 1'b1, 16'h0405);
        applyStimulus(32'h123452B7, 1'b0, 16'h0000);
        doFlush();
        doFlush();
        $display("[TB] c.lw + c.add");
        applyStimulus(32'h0004A403, 1'b1, 16'h4080);
        applyStimulus(32'h00B50533, 1'b1, 16'h952E);

        vecs.push_back('{32'h00000013, 1'b1, 16'h0001});
        vecs.push_back('{32'h00B00533, 1'b1, 16'h852E});
        vecs.push_back('{32'h00008067, 1'b1, 16'h8082});
        vecs.push_back('{32'h00942223, 1'b1, 16'hC044});
        vecs.push_back('{32'h06440413, 1'b0, 16'h0000});
        vecs.push_back('{32'hFE040413, 1'b1, 16'h1401});
        vecs.push_back('{32'h02040413, 1'b0, 16'h0000});
        vecs.push_back('{32'h01F40413, 1'b1, 16'h047D});
        vecs.push_back('{32'h0804A403, 1'b0, 16'h0000});
        vecs.push_back('{32'h07C4A403, 1'b1, 16'h5CE0});
        vecs.push_back('{32'hF00400E3, 1'b1, 16'hD001});
        vecs.push_back('{32'h00341413, 1'b1, 16'h040E});
        vecs.push_back('{32'h801FF0EF, 1'b1, 16'h3001});
        vecs.push_back('{32'h001000EF, 1'b0, 16'h0000});
        vecs.push_back('{32'h4044D493, 1'b1, 16'h8491});
        vecs.push_back('{32'hFFF57513, 1'b1, 16'h997D});
        vecs.push_back('{32'h123452B7, 1'b0, 16'h0000});

        $display("[TB] rule table with random backpressure");
        randBp = 1'b1;
        for (int r = 0; r < 2; r++)
            foreach (vecs[i])
                applyStimulus(vecs[i].canon, vecs[i].comp, vecs[i].parcel);
        randBp = 1'b0;
        doFlush();
        idle(3);

        $display("[TB] hold output under backpressure");
        out_ready = 1'b0;
        applyStimulus(32'h00140413, 1'b1, 16'h0405);
        applyStimulus(32'h00140413, 1'b1, 16'h0405);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_word", out_word, swap(32'h04050405));
        end
        n0 = xferCount;
        out_ready = 1'b1;
        idle(1);
        checkOutput("single_xfer", 32'(xferCount), 32'(n0 + 1));
        checkOutput("drained_valid", 32'(out_valid), 32'd0);
        idle(1);
        checkOutput("no_extra_xfer", 32'(xferCount), 32'(n0 + 1));

        $display("[TB] reset while a halfword and a word are outstanding");
        out_ready = 1'b0;
        applyStimulus(32'h00140413, 1'b1, 16'h0405);
        applyStimulus(32'h123452B7, 1'b0, 16'h0000);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_pending", 32'(pending), 32'd0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_out_word", out_word, 32'd0);
        sb.delete();
        mHalf = 1'b0;
        mPh   = '0;
        idle(1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(1);
        applyStimulus(32'h123452B7, 1'b0, 16'h0000);

        waited = 0;
        while (sb.size() > 0 && waited < 40) begin
            idle(1);
            waited++;
        end
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        idle(1);
        checkOutput("final_out_valid", 32'(out_valid), 32'd0);
        checkOutput("final_pending", 32'(pending), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
